// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, constants and helpers
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        POP    = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } tx_state_e;

    localparam int DATA_BITS     = 8;
    localparam int DIV_W_DEFAULT = 16;
    localparam bit LSB_FIRST     = 1'b1;

    function automatic logic frame_parity(input logic [DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - TX FIFO to serialiser pop handshake
interface uart_tx_if;
    logic                           fifo_empty;
    logic [uart_pkg::DATA_BITS-1:0] fifo_data;
    logic                           fifo_pop;

    modport master (output fifo_empty, output fifo_data, input fifo_pop);
    modport slave  (input fifo_empty, input fifo_data, output fifo_pop);
endinterface

// File: rtl/uart_baud_cnt.sv
// rtl/uart_baud_cnt.sv - loadable bit-period down-counter, flags the last cycle of each bit
module uart_baud_cnt #(
    parameter int DIV_W = uart_pkg::DIV_W_DEFAULT
) (
    input  logic             clk_in,
    input  logic             rstn,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             bit_end_o
);

    logic [DIV_W-1:0] cnt_q;

    // div_i is never zero here; the owner sanitises it before it arrives
    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= div_i - DIV_W'(1);
        end else if (en_i) begin
            cnt_q <= (cnt_q == '0) ? div_i - DIV_W'(1) : cnt_q - DIV_W'(1);
        end
    end

    assign bit_end_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - FIFO-fed asynchronous serial transmitter
module uart_tx
    import uart_pkg::*;
#(
    parameter int DIV_W  = DIV_W_DEFAULT,
    parameter int DATA_W = DATA_BITS
) (
    input  logic             clk_in,
    input  logic             rstn,
    input  logic             tx_en,
    input  logic [DIV_W-1:0] divisor,
    input  logic             parity_en,
    input  logic             parity_odd,
    input  logic             stop2,
    uart_tx_if.slave         fifo,
    output logic             txd,
    output logic             tx_busy,
    output logic             tx_done
);

    tx_state_e         state_q;
    logic [DATA_W-1:0] shift_q;
    logic [2:0]        idx_q;
    logic [DIV_W-1:0]  div_q;
    logic              par_en_q, par_bit_q, stop2_q;
    logic              txd_q, pop_q, busy_q, done_q;

    logic [DIV_W-1:0]  div_d;
    logic [DIV_W-1:0]  baud_div;
    logic              baud_clear, baud_en, bit_end;

    assign div_d      = (divisor == '0) ? DIV_W'(1) : divisor;
    // In LOAD the counter must see the divisor being latched, not the stale one
    assign baud_div   = (state_q == LOAD) ? div_d : div_q;
    assign baud_clear = (state_q == LOAD);
    assign baud_en    = (state_q == START) || (state_q == DATA) ||
                        (state_q == PARITY) || (state_q == STOP);

    uart_baud_cnt #(.DIV_W(DIV_W)) u_baud (
        .clk_in    (clk_in),
        .rstn      (rstn),
        .clear_i   (baud_clear),
        .en_i      (baud_en),
        .div_i     (baud_div),
        .bit_end_o (bit_end)
    );

    // Outputs are registered from the current state, so txd trails the state by one cycle
    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            idx_q     <= '0;
            div_q     <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            txd_q     <= 1'b1;
            pop_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            pop_q  <= 1'b0;
            done_q <= 1'b0;
            busy_q <= (state_q != IDLE);
            case (state_q)
                IDLE: begin
                    txd_q <= 1'b1;
                    if (tx_en && !fifo.fifo_empty) begin
                        pop_q   <= 1'b1;
                        state_q <= POP;
                    end
                end
                POP: begin
                    txd_q   <= 1'b1;
                    state_q <= LOAD;
                end
                LOAD: begin
                    txd_q     <= 1'b1;
                    shift_q   <= fifo.fifo_data;
                    div_q     <= div_d;
                    par_en_q  <= parity_en;
                    stop2_q   <= stop2;
                    par_bit_q <= frame_parity(fifo.fifo_data, parity_odd);
                    idx_q     <= '0;
                    state_q   <= START;
                end
                START: begin
                    txd_q <= 1'b0;
                    if (bit_end) begin
                        idx_q   <= '0;
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    txd_q <= LSB_FIRST ? shift_q[0] : shift_q[DATA_W-1];
                    if (bit_end) begin
                        shift_q <= LSB_FIRST ? (shift_q >> 1) : (shift_q << 1);
                        idx_q   <= idx_q + 3'd1;
                        if (idx_q == 3'(DATA_W-1)) begin
                            idx_q   <= '0;
                            state_q <= par_en_q ? PARITY : STOP;
                        end
                    end
                end
                PARITY: begin
                    txd_q <= par_bit_q;
                    if (bit_end) state_q <= STOP;
                end
                STOP: begin
                    txd_q <= 1'b1;
                    if (bit_end) begin
                        if (stop2_q && idx_q == '0) begin
                            idx_q <= 3'd1;
                        end else begin
                            idx_q   <= '0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    txd_q   <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign txd           = txd_q;
    assign tx_busy       = busy_q;
    assign tx_done       = done_q;
    assign fifo.fifo_pop = pop_q;

endmodule
